// File: rtl/ad5674_pkg.sv
// Shared types and defaults for the AD5674 write-channel arbiter.
package ad5674_pkg;

    localparam int unsigned AD5674_CH_W   = 5;
    localparam int unsigned AD5674_DATA_W = 12;
    localparam int unsigned DEF_TIMEOUT   = 4096;
    localparam int unsigned DEF_GAP_CYC   = 8;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWaitBusy,
        StWaitDone,
        StGap
    } arb_state_e;

endpackage

// File: rtl/ad5674_dac_arb_rr_grant.sv
// Combinational round-robin picker: first asserted request at or above rr_ptr, wrapping.
module rr_grant
    import ad5674_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any_valid
);

    int unsigned      sum;
    logic [IDX_W-1:0] idx;

    always_comb begin
        grant     = '0;
        any_valid = 1'b0;
        sum       = 0;
        idx       = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            sum = 32'(rr_ptr) + k;
            if (sum >= NUM_REQ) begin
                sum = sum - NUM_REQ;
            end
            idx = IDX_W'(sum);
            if (!any_valid && req[idx]) begin
                any_valid = 1'b1;
                grant     = idx;
            end
        end
    end

endmodule

// File: rtl/ad5674_dac_arb.sv
// Round-robin arbiter sharing one AD5674 write channel between NUM_REQ requesters,
// with per-transaction driver timeout and a fixed post-transaction gap.
module ad5674_dac_arb
    import ad5674_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned CH_W    = AD5674_CH_W,
    parameter int unsigned DATA_W  = AD5674_DATA_W,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT,
    parameter int unsigned GAP_CYC = DEF_GAP_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*CH_W-1:0]   req_ch,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ack,
    output logic [NUM_REQ-1:0]        req_done,
    output logic                      dac_trig,
    output logic [CH_W-1:0]           dac_ch,
    output logic [DATA_W-1:0]         dac_din,
    input  logic                      dac_busy,
    input  logic                      err_clr,
    output logic                      err_flag,
    output logic                      arb_busy
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = $clog2(GAP_CYC + 1);

    localparam logic [CNT_W-1:0]   CntLast = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   CntMax  = CNT_W'(TIMEOUT);
    localparam logic [GAP_W-1:0]   GapLast = GAP_W'(GAP_CYC - 1);
    localparam logic [IDX_W-1:0]   IdxLast = IDX_W'(NUM_REQ - 1);
    localparam logic [NUM_REQ-1:0] OneLsb  = NUM_REQ'(1);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]  grant_q, grant_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic [DATA_W-1:0] din_q, din_d;
    logic              err_q, err_d;

    logic              err_set;
    logic              timed_out;
    logic [CNT_W-1:0]  cnt_inc;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_any;
    logic [CH_W-1:0]   pick_ch;
    logic [DATA_W-1:0] pick_din;
    logic [NUM_REQ-1:0] grant_oh;

    rr_grant #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_grant (
        .req       (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (pick_idx),
        .any_valid (pick_any)
    );

    // Constant-index mux keeps the slice selects in range for any NUM_REQ.
    always_comb begin
        pick_ch  = '0;
        pick_din = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (pick_idx == IDX_W'(i)) begin
                pick_ch  = req_ch[i*CH_W +: CH_W];
                pick_din = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        gap_d     = gap_q;
        ch_d      = ch_q;
        din_d     = din_q;
        err_set   = 1'b0;
        timed_out = (cnt_q == CntLast);
        cnt_inc   = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;

        case (state_q)
            StIdle: begin
                if (pick_any) begin
                    state_d  = StIssue;
                    grant_d  = pick_idx;
                    rr_ptr_d = (pick_idx == IdxLast) ? '0 : pick_idx + 1'b1;
                    ch_d     = pick_ch;
                    din_d    = pick_din;
                end
            end
            StIssue: begin
                state_d = StWaitBusy;
                cnt_d   = '0;
            end
            StWaitBusy: begin
                if (dac_busy) begin
                    state_d = StWaitDone;
                    cnt_d   = '0;
                end else if (timed_out) begin
                    state_d = StGap;
                    gap_d   = '0;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StWaitDone: begin
                if (!dac_busy) begin
                    state_d = StGap;
                    gap_d   = '0;
                end else if (timed_out) begin
                    state_d = StGap;
                    gap_d   = '0;
                    err_set = 1'b1;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            StGap: begin
                if (gap_q == GapLast) begin
                    state_d = StIdle;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        // A new timeout outranks a simultaneous clear.
        err_d = err_set | (err_q & ~err_clr);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            ch_q     <= '0;
            din_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            ch_q     <= ch_d;
            din_q    <= din_d;
            err_q    <= err_d;
        end
    end

    // Strobes decode from registered state, so reset clears them asynchronously.
    assign grant_oh = OneLsb << grant_q;
    assign dac_trig = (state_q == StIssue);
    assign req_ack  = dac_trig ? grant_oh : '0;
    assign req_done = (state_q == StGap && gap_q == GapLast) ? grant_oh : '0;
    assign dac_ch   = ch_q;
    assign dac_din  = din_q;
    assign err_flag = err_q;
    assign arb_busy = (state_q != StIdle);

endmodule

// File: tb/tb_ad5674_dac_arb.sv
// Scoreboard bench for ad5674_dac_arb with a configurable driver busy model.
module tb_ad5674_dac_arb;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned CH_W    = 5;
    localparam int unsigned DATA_W  = 12;
    localparam int unsigned TIMEOUT = 64;
    localparam int unsigned GAP_CYC = 8;

    typedef struct {
        int                idx;
        logic [CH_W-1:0]   ch;
        logic [DATA_W-1:0] din;
    } exp_t;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*CH_W-1:0]   req_ch;
    logic [NUM_REQ*DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]        req_ack;
    logic [NUM_REQ-1:0]        req_done;
    logic                      dac_trig;
    logic [CH_W-1:0]           dac_ch;
    logic [DATA_W-1:0]         dac_din;
    logic                      dac_busy;
    logic                      err_clr;
    logic                      err_flag;
    logic                      arb_busy;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   trig_cnt = 0;
    exp_t sb[$];

    // Busy model: 0 = normal pulse, 1 = never rises, 2 = stays high until released.
    int   bm_mode    = 0;
    int   bm_dly     = 1;
    int   bm_hold    = 4;
    bit   bm_release = 1'b0;
    bit   bm_kill    = 1'b0;
    int   bm_fall_cyc = 0;

    ad5674_dac_arb #(
        .NUM_REQ (NUM_REQ),
        .CH_W    (CH_W),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .GAP_CYC (GAP_CYC)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ch    (req_ch),
        .req_data  (req_data),
        .req_ack   (req_ack),
        .req_done  (req_done),
        .dac_trig  (dac_trig),
        .dac_ch    (dac_ch),
        .dac_din   (dac_din),
        .dac_busy  (dac_busy),
        .err_clr   (err_clr),
        .err_flag  (err_flag),
        .arb_busy  (arb_busy)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial forever begin
        @(negedge clk);
        if (dac_trig === 1'b1) trig_cnt++;
    end

    initial begin
        int phase;
        int cnt;
        phase    = 0;
        cnt      = 0;
        dac_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (bm_kill) begin
                dac_busy = 1'b0;
                phase    = 0;
            end else begin
                case (phase)
                    0: if (dac_trig === 1'b1 && bm_mode != 1) begin
                        cnt   = bm_dly;
                        phase = 1;
                    end
                    1: begin
                        cnt--;
                        if (cnt <= 0) begin
                            dac_busy = 1'b1;
                            cnt      = bm_hold;
                            phase    = 2;
                        end
                    end
                    2: begin
                        if (bm_mode == 2) begin
                            if (bm_release) begin
                                dac_busy    = 1'b0;
                                bm_fall_cyc = cyc;
                                phase       = 0;
                            end
                        end else begin
                            cnt--;
                            if (cnt <= 0) begin
                                dac_busy    = 1'b0;
                                bm_fall_cyc = cyc;
                                phase       = 0;
                            end
                        end
                    end
                    default: phase = 0;
                endcase
            end
        end
    end

    task automatic set_slot(input int i, input logic [CH_W-1:0] ch, input logic [DATA_W-1:0] din);
        req_ch[i*CH_W +: CH_W]       = ch;
        req_data[i*DATA_W +: DATA_W] = din;
    endtask

    task automatic wait_trig(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (dac_trig === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_idle(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (arb_busy === 1'b0) begin
                seen = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_done(input int budget, output bit seen, output logic [NUM_REQ-1:0] val,
                             output int at);
        seen = 1'b0;
        val  = '0;
        at   = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (req_done !== '0) begin
                seen = 1'b1;
                val  = req_done;
                at   = cyc;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (dac_trig !== 1'b0) begin failures++; $display("FAIL reset_trig got=%b want=0", dac_trig); end
        checks++; if (dac_ch !== '0) begin failures++; $display("FAIL reset_ch got=%0h want=0", dac_ch); end
        checks++; if (dac_din !== '0) begin failures++; $display("FAIL reset_din got=%0h want=0", dac_din); end
        checks++; if (req_ack !== '0) begin failures++; $display("FAIL reset_ack got=%b want=0", req_ack); end
        checks++; if (req_done !== '0) begin failures++; $display("FAIL reset_done got=%b want=0", req_done); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err_flag); end
        checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", arb_busy); end
    endtask

    task automatic test_fairness();
        exp_t e;
        bit seen;
        int trig0;
        logic [NUM_REQ-1:0] exp_ack;
        bm_mode = 0; bm_dly = 1; bm_hold = 4;
        trig0 = trig_cnt;
        for (int i = 0; i < NUM_REQ; i++) begin
            e.idx = i; e.ch = CH_W'(i * 5 + 1); e.din = DATA_W'(256 * i + 1);
            set_slot(e.idx, e.ch, e.din);
            sb.push_back(e);
        end
        req_valid = '1;
        for (int n = 0; n < 6; n++) begin
            wait_trig(200, seen);
            checks++;
            if (!seen) begin failures++; $display("FAIL fair_trig_timeout n=%0d got=none want=trig", n); break; end
            e = sb.pop_front();
            exp_ack = '0; exp_ack[e.idx] = 1'b1;
            checks++; if (req_ack !== exp_ack) begin failures++; $display("FAIL fair_ack n=%0d got=%b want=%b", n, req_ack, exp_ack); end
            checks++; if (dac_ch !== e.ch) begin failures++; $display("FAIL fair_ch n=%0d got=%0h want=%0h", n, dac_ch, e.ch); end
            checks++; if (dac_din !== e.din) begin failures++; $display("FAIL fair_din n=%0d got=%0h want=%0h", n, dac_din, e.din); end
            e.ch = e.ch + 1'b1; e.din = e.din + 12'h010;
            set_slot(e.idx, e.ch, e.din);
            sb.push_back(e);
            if (n == 5) req_valid = '0;
        end
        sb.delete();
        wait_idle(200, seen);
        checks++; if (!seen) begin failures++; $display("FAIL fair_idle got=busy want=idle"); end
        checks++; if (trig_cnt - trig0 != 6) begin failures++; $display("FAIL fair_trig_count got=%0d want=6", trig_cnt - trig0); end
    endtask

    task automatic test_single();
        exp_t e;
        bit seen;
        int at;
        logic [NUM_REQ-1:0] dval;
        bm_mode = 0; bm_dly = 3; bm_hold = 20;
        wait_idle(200, seen);
        e.idx = 2; e.ch = 5'd7; e.din = 12'hA5C;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b0100;
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (dac_trig !== 1'b1) begin failures++; $display("FAIL single_trig_latency got=%b want=1", dac_trig); end
        checks++; if (req_ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%b want=0100", req_ack); end
        checks++; if (dac_ch !== e.ch) begin failures++; $display("FAIL single_ch got=%0d want=%0d", dac_ch, e.ch); end
        checks++; if (dac_din !== e.din) begin failures++; $display("FAIL single_din got=%0h want=%0h", dac_din, e.din); end
        req_valid = '0;
        wait_done(100, seen, dval, at);
        checks++; if (!seen) begin failures++; $display("FAIL single_done_timeout got=none want=done"); end
        checks++; if (dval !== 4'b0100) begin failures++; $display("FAIL single_done got=%b want=0100", dval); end
        checks++; if (at != bm_fall_cyc + int'(GAP_CYC)) begin failures++; $display("FAIL single_done_cycle got=%0d want=%0d", at, bm_fall_cyc + int'(GAP_CYC)); end
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL single_err got=%b want=0", err_flag); end
    endtask

    task automatic test_rr_ptr();
        exp_t e;
        bit seen;
        logic [NUM_REQ-1:0] exp_ack;
        bm_mode = 0; bm_dly = 1; bm_hold = 3;
        wait_idle(200, seen);
        // Serving requester 1 alone leaves the pointer at 2.
        e.idx = 1; e.ch = 5'd11; e.din = 12'h111;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b0010;
        wait_trig(20, seen);
        e = sb.pop_front();
        checks++; if (!seen || req_ack !== 4'b0010) begin failures++; $display("FAIL rr_setup_ack got=%b want=0010", req_ack); end
        req_valid = '0;
        wait_idle(200, seen);
        e.idx = 3; e.ch = 5'd13; e.din = 12'h333;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        e.idx = 1; e.ch = 5'd21; e.din = 12'h121;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b1010;
        for (int n = 0; n < 2; n++) begin
            wait_trig(200, seen);
            checks++;
            if (!seen) begin failures++; $display("FAIL rr_trig_timeout n=%0d got=none want=trig", n); break; end
            e = sb.pop_front();
            exp_ack = '0; exp_ack[e.idx] = 1'b1;
            checks++; if (req_ack !== exp_ack) begin failures++; $display("FAIL rr_order n=%0d got=%b want=%b", n, req_ack, exp_ack); end
            checks++; if (dac_din !== e.din) begin failures++; $display("FAIL rr_din n=%0d got=%0h want=%0h", n, dac_din, e.din); end
            req_valid[e.idx] = 1'b0;
        end
        req_valid = '0;
        wait_idle(200, seen);
    endtask

    task automatic test_hang();
        exp_t e;
        bit seen;
        int t;
        int t2;
        int at;
        logic [NUM_REQ-1:0] dval;
        bm_mode = 1;
        wait_idle(200, seen);
        e.idx = 0; e.ch = 5'd3; e.din = 12'h0F0;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b0001;
        wait_trig(20, seen);
        e = sb.pop_front();
        checks++; if (!seen || req_ack !== 4'b0001) begin failures++; $display("FAIL hang_ack got=%b want=0001", req_ack); end
        t = cyc;
        req_valid = '0;
        seen = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) + 20; i++) begin
            @(negedge clk);
            if (err_flag === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (!seen) begin failures++; $display("FAIL hang_err_timeout got=0 want=1"); end
        checks++; if (cyc != t + int'(TIMEOUT) + 1) begin failures++; $display("FAIL hang_err_cycle got=%0d want=%0d", cyc, t + int'(TIMEOUT) + 1); end
        e.idx = 1; e.ch = 5'd5; e.din = 12'h5A5;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b0010;
        wait_done(GAP_CYC + 4, seen, dval, at);
        checks++; if (!seen || dval !== 4'b0001) begin failures++; $display("FAIL hang_done got=%b want=0001", dval); end
        checks++; if (at != t + int'(TIMEOUT) + int'(GAP_CYC)) begin failures++; $display("FAIL hang_done_cycle got=%0d want=%0d", at, t + int'(TIMEOUT) + int'(GAP_CYC)); end
        wait_trig(10, seen);
        e = sb.pop_front();
        checks++; if (!seen || req_ack !== 4'b0010) begin failures++; $display("FAIL hang_next_ack got=%b want=0010", req_ack); end
        checks++; if (dac_din !== e.din) begin failures++; $display("FAIL hang_next_din got=%0h want=%0h", dac_din, e.din); end
        t2 = cyc;
        req_valid = '0;
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL hang_err_clear got=%b want=0", err_flag); end
        repeat (TIMEOUT - 1) @(negedge clk);
        checks++; if (err_flag !== 1'b0) begin failures++; $display("FAIL hang_err_early got=%b want=0 at=%0d", err_flag, cyc - t2); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++; if (err_flag !== 1'b1) begin failures++; $display("FAIL hang_set_beats_clr got=%b want=1", err_flag); end
        wait_idle(200, seen);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        bm_mode = 0;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit seen;
        bm_mode = 0; bm_dly = 2; bm_hold = 200;
        wait_idle(200, seen);
        e.idx = 2; e.ch = 5'd17; e.din = 12'hC0D;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b0100;
        wait_trig(20, seen);
        e = sb.pop_front();
        checks++; if (!seen || req_ack !== 4'b0100) begin failures++; $display("FAIL rstmid_ack got=%b want=0100", req_ack); end
        req_valid = '0;
        repeat (10) @(negedge clk);
        checks++; if (arb_busy !== 1'b1) begin failures++; $display("FAIL rstmid_in_flight got=%b want=1", arb_busy); end
        // Pointer now sits at 3; pending 0 and 3 show whether reset cleared it.
        set_slot(0, 5'd4, 12'h404);
        set_slot(3, 5'd30, 12'h3F3);
        req_valid = 4'b1001;
        #2 rst = 1'b1;
        bm_kill = 1'b1;
        #1;
        checks++; if (arb_busy !== 1'b0) begin failures++; $display("FAIL rstmid_async_busy got=%b want=0", arb_busy); end
        checks++; if (dac_ch !== '0 || dac_din !== '0) begin failures++; $display("FAIL rstmid_async_data got=%0h/%0h want=0/0", dac_ch, dac_din); end
        checks++; if (dac_trig !== 1'b0 || req_done !== '0) begin failures++; $display("FAIL rstmid_async_strobes got=%b/%b want=0/0", dac_trig, req_done); end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++; if (req_done !== '0 || req_ack !== '0) begin failures++; $display("FAIL rstmid_no_done got=%b/%b want=0/0", req_done, req_ack); end
        end
        bm_hold = 4;
        e.idx = 0; e.ch = 5'd4; e.din = 12'h404;
        sb.push_back(e);
        rst = 1'b0;
        bm_kill = 1'b0;
        @(negedge clk);
        e = sb.pop_front();
        checks++; if (req_ack !== 4'b0001) begin failures++; $display("FAIL rstmid_grant0 got=%b want=0001", req_ack); end
        checks++; if (dac_ch !== e.ch || dac_din !== e.din) begin failures++; $display("FAIL rstmid_data got=%0h/%0h want=%0h/%0h", dac_ch, dac_din, e.ch, e.din); end
        req_valid = '0;
        wait_idle(200, seen);
    endtask

    task automatic test_stuck();
        exp_t e;
        bit seen;
        int t;
        int at;
        int bad;
        logic [CH_W-1:0] last_ch;
        logic [DATA_W-1:0] last_din;
        logic [NUM_REQ-1:0] dval;
        bm_mode = 2; bm_dly = 1; bm_release = 1'b0;
        wait_idle(200, seen);
        e.idx = 1; e.ch = 5'd9; e.din = 12'h3C3;
        set_slot(e.idx, e.ch, e.din);
        sb.push_back(e);
        req_valid = 4'b0010;
        wait_trig(20, seen);
        e = sb.pop_front();
        checks++; if (!seen || req_ack !== 4'b0010) begin failures++; $display("FAIL stuck_ack got=%b want=0010", req_ack); end
        t = cyc;
        req_valid = '0;
        set_slot(1, 5'd0, 12'h000);
        bad = 0; last_ch = e.ch; last_din = e.din; seen = 1'b0;
        for (int i = 0; i < int'(TIMEOUT) + 20; i++) begin
            @(negedge clk);
            if (dac_ch !== e.ch || dac_din !== e.din) begin bad++; last_ch = dac_ch; last_din = dac_din; end
            if (err_flag === 1'b1) begin seen = 1'b1; break; end
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL stuck_data_stable got=%0h/%0h want=%0h/%0h", last_ch, last_din, e.ch, e.din); end
        checks++; if (!seen) begin failures++; $display("FAIL stuck_err_timeout got=0 want=1"); end
        checks++; if (cyc != t + int'(TIMEOUT) + 2) begin failures++; $display("FAIL stuck_err_cycle got=%0d want=%0d", cyc, t + int'(TIMEOUT) + 2); end
        wait_done(GAP_CYC + 4, seen, dval, at);
        checks++; if (!seen || dval !== 4'b0010) begin failures++; $display("FAIL stuck_done got=%b want=0010", dval); end
        bm_release = 1'b1;
        repeat (3) @(negedge clk);
        bm_release = 1'b0;
        bm_mode = 0;
        checks++; if (dac_ch !== e.ch || dac_din !== e.din) begin failures++; $display("FAIL stuck_hold_idle got=%0h/%0h want=%0h/%0h", dac_ch, dac_din, e.ch, e.din); end
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_ch    = '0;
        req_data  = '0;
        err_clr   = 1'b0;
        test_reset();
        test_fairness();
        test_single();
        test_rr_ptr();
        test_hang();
        test_reset_mid();
        test_stuck();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
